// File: rtl/ram_arbiter_if.sv
// Requester handshakes and RAM control pins for the two-port RAM arbiter.
// The shared tri-state data bus is carried separately as an inout port of the arbiter.
interface ram_arbiter_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 8
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [AWIDTH-1:0] addr0;
    logic [AWIDTH-1:0] addr1;
    logic [DWIDTH-1:0] wdata0;
    logic [DWIDTH-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic [DWIDTH-1:0] rdata;
    logic              busy;
    logic              ram_rd_en;
    logic              ram_wr_en;
    logic [AWIDTH-1:0] ram_addr;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output ack0, ack1, rdata, busy, ram_rd_en, ram_wr_en, ram_addr
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, rdata, busy, ram_rd_en, ram_wr_en, ram_addr
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter serialising two requesters onto a single-port RAM,
// one transaction every three clocks (IDLE -> ACCESS -> RESP).
module ram_arbiter #(
    parameter int DWIDTH   = 32,
    parameter int MEMDEPTH = 256,
    parameter int AWIDTH   = $clog2(MEMDEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_arbiter_if.slave      bus,
    inout  wire  [DWIDTH-1:0] ram_data
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_q, grant_d;
    logic              we_q, we_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              rd_en_q, rd_en_d;
    logic              wr_en_q, wr_en_d;
    logic              busy_q, busy_d;
    logic              grant_s;

    // With both requesting, the one not served last wins.
    assign grant_s = (bus.req0 & bus.req1) ? ~last_grant_q : bus.req1;

    // wr_en_q is only ever set in ACCESS, so the bus is released everywhere else.
    assign ram_data      = wr_en_q ? wdata_q : {DWIDTH{1'bz}};
    assign bus.ram_addr  = addr_q;
    assign bus.ram_rd_en = rd_en_q;
    assign bus.ram_wr_en = wr_en_q;
    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = busy_q;

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        rd_en_d      = 1'b0;
        wr_en_d      = 1'b0;
        busy_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req0 | bus.req1) begin
                    grant_d      = grant_s;
                    last_grant_d = grant_s;
                    we_d         = grant_s ? bus.we1    : bus.we0;
                    addr_d       = grant_s ? bus.addr1  : bus.addr0;
                    wdata_d      = grant_s ? bus.wdata1 : bus.wdata0;
                    rd_en_d      = ~(grant_s ? bus.we1 : bus.we0);
                    wr_en_d      = grant_s ? bus.we1 : bus.we0;
                    busy_d       = 1'b1;
                    state_d      = ACCESS;
                end else begin
                    state_d      = IDLE;
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    rdata_d = ram_data;
                end else begin
                    rdata_d = rdata_q;
                end
                ack0_d  = ~grant_q;
                ack1_d  = grant_q;
                busy_d  = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= {AWIDTH{1'b0}};
            wdata_q      <= {DWIDTH{1'b0}};
            rdata_q      <= {DWIDTH{1'b0}};
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rd_en_q      <= rd_en_d;
            wr_en_q      <= wr_en_d;
            busy_q       <= busy_d;
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-level reference model.
module tb_ram_arbiter;
    localparam int DW    = 32;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic clk = 1'b0;
    logic rst_n;
    ram_arbiter_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();
    wire [DW-1:0] ram_data;

    logic [DW-1:0] mem     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int acc_edge;
    int free_edge;
    bit last_grant;
    bit m_grant, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    ram_arbiter #(.DWIDTH(DW), .MEMDEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .ram_data (ram_data)
    );

    always #5 clk = ~clk;

    // RAM drives the bus only while it is being read.
    assign ram_data = bus.ram_rd_en ? mem[bus.ram_addr] : {DW{1'bz}};

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic reset_model();
        acc_edge   = -100;
        free_edge  = 0;
        last_grant = 1'b1;
        m_rdata    = '0;
    endtask

    // One transaction occupies three edges; memory effect lands on the edge after acceptance.
    task automatic model_edge();
        if (!rst_n) return;
        if (edge_n == acc_edge + 1) begin
            if (m_we) ref_mem[m_addr] = m_wdata;
            else      m_rdata = ref_mem[m_addr];
        end
        if (edge_n >= free_edge && (bus.req0 || bus.req1)) begin
            m_grant    = (bus.req0 && bus.req1) ? ~last_grant : bus.req1;
            last_grant = m_grant;
            m_we       = m_grant ? bus.we1    : bus.we0;
            m_addr     = m_grant ? bus.addr1  : bus.addr0;
            m_wdata    = m_grant ? bus.wdata1 : bus.wdata0;
            acc_edge   = edge_n;
            free_edge  = edge_n + 3;
        end
    endtask

    task automatic check_cycle();
        int d;
        d = edge_n - acc_edge;
        check_eq("busy",  bus.busy,  (d == 0 || d == 1));
        check_eq("ack0",  bus.ack0,  (d == 1 && !m_grant));
        check_eq("ack1",  bus.ack1,  (d == 1 && m_grant));
        check_eq("rd_en", bus.ram_rd_en, (d == 0 && !m_we));
        check_eq("wr_en", bus.ram_wr_en, (d == 0 && m_we));
        check_eq("rdata", bus.rdata, m_rdata);
        if (d == 0) begin
            check_eq("ram_addr", bus.ram_addr, m_addr);
            if (m_we) begin
                check_eq("bus_wdata", ram_data, m_wdata);
            end else begin
                check_eq("bus_known", $isunknown(ram_data), 1'b0);
                check_eq("bus_rdata", ram_data, ref_mem[m_addr]);
            end
        end
    endtask

    task automatic step();
        logic          pend_wr;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        pend_wr = bus.ram_wr_en;
        pa      = bus.ram_addr;
        pd      = ram_data;
        @(posedge clk);
        if (pend_wr && rst_n) mem[pa] = pd;
        edge_n++;
        model_edge();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic set_req(input int n, input bit r, input bit we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (n == 0) begin
            bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    task automatic new_rand(input int n);
        logic [AW-1:0] a;
        a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
        set_req(n, 1'b1, 1'($urandom_range(0, 1)), a, $urandom);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        reset_model();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        #1;
        check_eq("rst_ack0",  bus.ack0, 1'b0);
        check_eq("rst_ack1",  bus.ack1, 1'b0);
        check_eq("rst_rd_en", bus.ram_rd_en, 1'b0);
        check_eq("rst_wr_en", bus.ram_wr_en, 1'b0);
        check_eq("rst_busy",  bus.busy, 1'b0);
        check_eq("rst_rdata", bus.rdata, '0);
        check_eq("rst_addr",  bus.ram_addr, '0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic run_until_ack(input int n, input int budget, output int at_edge);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            step();
            if ((n == 0 && bus.ack0) || (n == 1 && bus.ack1)) got = 1'b1;
        end
        at_edge = edge_n;
        check_eq("ack_timeout", got, 1'b1);
    endtask

    task automatic drive_rand();
        bit a0, a1;
        a0 = bus.ack0;
        a1 = bus.ack1;
        for (int n = 0; n < 2; n++) begin
            bit acked, cur;
            acked = (n == 0) ? a0 : a1;
            cur   = (n == 0) ? bus.req0 : bus.req1;
            if (acked) begin
                if ($urandom_range(0, 2) == 0) set_req(n, 1'b0, 1'b0, '0, '0);
                else new_rand(n);
            end else if (!cur && $urandom_range(0, 3) == 0) begin
                new_rand(n);
            end
        end
    endtask

    initial begin
        int at, s, prev, who, busy_cnt;
        logic [DW-1:0] old5;
        bit got;
        rst_n = 1'b1;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        reset_model();
        #2;
        do_reset();

        // Write then read from requester 0 alone.
        s = edge_n;
        set_req(0, 1'b1, 1'b1, 8'h00, 32'hFFFFFFFF);
        run_until_ack(0, 10, at);
        check_eq("t1_wr_latency", at - s, 2);
        set_req(0, 1'b1, 1'b0, 8'h00, 32'h0);
        s = edge_n;
        run_until_ack(0, 10, at);
        check_eq("t1_rd_latency", at - s, 3);
        check_eq("t1_rdata", bus.rdata, 32'hFFFFFFFF);
        set_req(0, 1'b0, 1'b0, '0, '0);
        step();

        // Contention right after reset: requester 0 first.
        do_reset();
        set_req(0, 1'b1, 1'b1, 8'h01, 32'h11111111);
        set_req(1, 1'b1, 1'b0, 8'h01, 32'h0);
        run_until_ack(0, 10, at);
        check_eq("t2_first_ack1", bus.ack1, 1'b0);
        set_req(0, 1'b0, 1'b0, '0, '0);
        run_until_ack(1, 10, at);
        check_eq("t2_rdata", bus.rdata, 32'h11111111);
        set_req(1, 1'b0, 1'b0, '0, '0);
        step();

        // Fairness: both held high, grants alternate with 3-cycle spacing.
        new_rand(0);
        new_rand(1);
        prev = -1;
        for (int k = 0; k < 6; k++) begin
            got = 1'b0;
            for (int i = 0; i < 10 && !got; i++) begin
                step();
                if (bus.ack0 || bus.ack1) got = 1'b1;
            end
            check_eq("t3_ack_timeout", got, 1'b1);
            who = bus.ack1 ? 1 : 0;
            check_eq("t3_grant", who, k % 2);
            if (prev >= 0) check_eq("t3_spacing", edge_n - prev, 3);
            prev = edge_n;
            new_rand(who);
        end
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        step();
        step();

        // Reset during the ACCESS cycle of a write.
        old5 = ref_mem[5];
        set_req(0, 1'b1, 1'b1, 8'h05, 32'hDEADBEEF);
        step();
        check_eq("t5_in_access", bus.ram_wr_en, 1'b1);
        do_reset();
        step();
        check_eq("t5_no_ack", bus.ack0, 1'b0);
        set_req(0, 1'b1, 1'b0, 8'h05, 32'h0);
        run_until_ack(0, 10, at);
        check_eq("t5_old_value", bus.rdata, old5);
        set_req(0, 1'b0, 1'b0, '0, '0);
        step();

        // Read of the top address while requester 1 toggles mid-transaction.
        set_req(0, 1'b1, 1'b0, 8'hFF, 32'h0);
        busy_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.busy) busy_cnt++;
            if (i == 0) begin
                check_eq("t6_addr", bus.ram_addr, 8'hFF);
                set_req(1, 1'b1, 1'b1, 8'h10, 32'hA5A5A5A5);
            end
            if (i == 1) begin
                set_req(1, 1'b0, 1'b0, '0, '0);
                set_req(0, 1'b0, 1'b0, '0, '0);
            end
        end
        check_eq("t6_busy_cycles", busy_cnt, 2);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step();
            drive_rand();
        end
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
